// File: rtl/cornigera_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cornigera_pkg
// Description : Shared core types: datapath word, register address, the
//               operand-fetch sequencer state encoding and the x0 address.
// Revision    : 1.0 - initial release
// ============================================================================
package cornigera_pkg;

  typedef logic [31:0] DataType;
  typedef logic [4:0]  RegAddrType;

  localparam RegAddrType REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ2 = 2'd1,
    WAIT2 = 2'd2,
    VALID = 2'd3
  } regseq_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Operand-fetch controller for a 1R/1W register file. Issues
//               rs1 then rs2 to the synchronous read port, returns both
//               operands to execute through a valid/ready handshake, and
//               passes writeback onto the register-file write port.
//               Same-cycle write/read hazards are bypassed and captured
//               operands track later writebacks until consumed.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_*                 - decode request (rs1, rs2, use_rs2)
//               op_*                  - operands to execute (valid/ready)
//               wb_*                  - writeback from the pipeline
//               rf_write_*            - register-file write port
//               rf_read_from/_data    - register-file read port (1-cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer
  import cornigera_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req_valid,
  output logic       req_ready,
  input  RegAddrType req_rs1,
  input  RegAddrType req_rs2,
  input  logic       req_use_rs2,

  output logic       op_valid,
  input  logic       op_ready,
  output DataType    op_rs1_data,
  output DataType    op_rs2_data,

  input  logic       wb_valid,
  input  RegAddrType wb_rd,
  input  DataType    wb_data,

  output logic       rf_write_en,
  output RegAddrType rf_write_to,
  output DataType    rf_write_data,
  output RegAddrType rf_read_from,
  input  DataType    rf_read_data
);

  // A read and a write to the same address in one cycle: the register file
  // returns the old value, so the write data must be substituted.
  function automatic logic f_bypass_hit(input logic       wen,
                                        input RegAddrType wto,
                                        input RegAddrType rfrom);
    return wen && (wto == rfrom);
  endfunction

  // Writeback targeting a captured (or being-captured) source register.
  function automatic logic f_snoop_hit(input logic       wbv,
                                       input RegAddrType rd,
                                       input RegAddrType src);
    return wbv && (rd != REG_ZERO) && (rd == src);
  endfunction

  regseq_state_e r_state;
  regseq_state_e w_next_state;

  RegAddrType r_rs1;
  RegAddrType r_rs2;
  logic       r_use_rs2;

  logic       r_byp_hit;
  DataType    r_byp_data;

  DataType    r_op_rs1;
  DataType    r_op_rs2;

  RegAddrType w_read_from;
  logic       w_read_issue;
  DataType    w_capture_data;
  logic       w_snoop1;
  logic       w_snoop2;

  // --------------------------------------------------------------------------
  // Write port: pure pass-through, x0 writes suppressed.
  // --------------------------------------------------------------------------
  assign rf_write_en   = wb_valid && (wb_rd != REG_ZERO);
  assign rf_write_to   = wb_rd;
  assign rf_write_data = wb_data;

  assign rf_read_from  = w_read_from;

  assign w_capture_data = r_byp_hit ? r_byp_data : rf_read_data;
  assign w_snoop1       = f_snoop_hit(wb_valid, wb_rd, r_rs1);
  assign w_snoop2       = f_snoop_hit(wb_valid, wb_rd, r_rs2);

  assign op_rs1_data = r_op_rs1;
  assign op_rs2_data = r_op_rs2;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    op_valid     = 1'b0;
    w_read_from  = r_rs2;
    w_read_issue = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready   = 1'b1;
        // rs1 is issued in the accept cycle itself to save a cycle.
        w_read_from = req_rs1;
        if (req_valid) begin
          w_read_issue = 1'b1;
          w_next_state = READ2;
        end
      end
      READ2: begin
        w_read_from = r_rs2;
        if (r_use_rs2) begin
          w_read_issue = 1'b1;
          w_next_state = WAIT2;
        end else begin
          w_next_state = VALID;
        end
      end
      WAIT2: begin
        w_next_state = VALID;
      end
      VALID: begin
        op_valid = 1'b1;
        if (op_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, bypass capture and operand registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1      <= REG_ZERO;
      r_rs2      <= REG_ZERO;
      r_use_rs2  <= 1'b0;
      r_byp_hit  <= 1'b0;
      r_byp_data <= '0;
      r_op_rs1   <= '0;
      r_op_rs2   <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_rs1     <= req_rs1;
        r_rs2     <= req_rs2;
        r_use_rs2 <= req_use_rs2;
      end

      if (w_read_issue) begin
        r_byp_hit  <= f_bypass_hit(rf_write_en, rf_write_to, rf_read_from);
        r_byp_data <= wb_data;
      end

      case (r_state)
        READ2: begin
          // A write landing on the capture edge is newer than either the
          // array data or the bypassed value.
          r_op_rs1 <= w_snoop1 ? wb_data : w_capture_data;
          if (!r_use_rs2) begin
            r_op_rs2 <= '0;
          end
        end
        WAIT2: begin
          if (w_snoop1) begin
            r_op_rs1 <= wb_data;
          end
          r_op_rs2 <= w_snoop2 ? wb_data : w_capture_data;
        end
        VALID: begin
          if (w_snoop1) begin
            r_op_rs1 <= wb_data;
          end
          // One-operand requests keep rs2 at zero regardless of writes.
          if (r_use_rs2 && w_snoop2) begin
            r_op_rs2 <= wb_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Self-checking bench for regfile_sequencer. Provides a
//               behavioural register file, directed scenarios and random
//               traffic; a negedge monitor compares consumed operands and
//               latency against an architectural register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;
  import cornigera_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  RegAddrType req_rs1;
  RegAddrType req_rs2;
  logic       req_use_rs2;
  logic       op_valid;
  logic       op_ready;
  DataType    op_rs1_data;
  DataType    op_rs2_data;
  logic       wb_valid;
  RegAddrType wb_rd;
  DataType    wb_data;
  logic       rf_write_en;
  RegAddrType rf_write_to;
  DataType    rf_write_data;
  RegAddrType rf_read_from;
  DataType    rf_read_data;

  regfile_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_use_rs2   (req_use_rs2),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_rs1_data   (op_rs1_data),
    .op_rs2_data   (op_rs2_data),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_write_en   (rf_write_en),
    .rf_write_to   (rf_write_to),
    .rf_write_data (rf_write_data),
    .rf_read_from  (rf_read_from),
    .rf_read_data  (rf_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file: synchronous read, old data on same-cycle write, x0 = 0.
  DataType mem [32];
  always @(posedge clk) begin
    rf_read_data <= (rf_read_from == 5'd0) ? 32'd0 : mem[rf_read_from];
    if (rf_write_en) mem[rf_write_to] <= rf_write_data;
  end

  // Reference model and scoreboard
  typedef struct {
    RegAddrType rs1;
    RegAddrType rs2;
    logic       use2;
    int         acc_cyc;
  } req_t;

  req_t    exp_q[$];
  DataType arch [32];
  logic    seen_valid = 1'b0;

  function automatic DataType arch_val(input RegAddrType r);
    return (r == 5'd0) ? 32'd0 : arch[r];
  endfunction

  always @(negedge clk) begin
    check("rf_write_en", {31'd0, rf_write_en}, {31'd0, wb_valid && (wb_rd != 5'd0)});
    if (wb_valid && wb_rd != 5'd0) begin
      check("rf_write_to", {27'd0, rf_write_to}, {27'd0, wb_rd});
      check("rf_write_data", rf_write_data, wb_data);
    end
    if (!rst_n) begin
      exp_q.delete();
      seen_valid = 1'b0;
      check("op_valid_in_reset", {31'd0, op_valid}, 32'd0);
    end else begin
      if (op_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (exp_q.size() == 0) begin
          check("op_valid_without_request", {31'd0, op_valid}, 32'd0);
        end else begin
          check("latency", cyc - exp_q[0].acc_cyc, exp_q[0].use2 ? 32'd3 : 32'd2);
        end
      end
      if (op_valid && op_ready && exp_q.size() != 0) begin
        req_t r;
        r = exp_q.pop_front();
        check("op_rs1_data", op_rs1_data, arch_val(r.rs1));
        check("op_rs2_data", op_rs2_data, r.use2 ? arch_val(r.rs2) : 32'd0);
        seen_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        req_t n;
        n.rs1 = req_rs1; n.rs2 = req_rs2; n.use2 = req_use_rs2; n.acc_cyc = cyc;
        exp_q.push_back(n);
      end
    end
    // Writes of this cycle commit on the next edge, after the compares above.
    if (wb_valid && wb_rd != 5'd0) arch[wb_rd] = wb_data;
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      op_ready = $urandom_range(0, 1) == 1;
    end
  endtask

  task automatic send(input RegAddrType rs1, input RegAddrType rs2, input logic use2);
    int n;
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_use_rs2 = use2;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(req_ready && exp_q.size() == 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("idle_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!op_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("op_valid_timeout", {31'd0, op_valid}, 32'd1);
  endtask

  task automatic write_reg(input RegAddrType rd, input DataType d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_use_rs2 = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_op_valid", {31'd0, op_valid}, 32'd0);
    check("reset_op_rs1", op_rs1_data, 32'd0);
    check("reset_op_rs2", op_rs2_data, 32'd0);

    // Give every register a defined value, then the planned preloads.
    for (int r = 1; r < 32; r++) write_reg(5'(r), $urandom);
    write_reg(5'd5, 32'h11);
    write_reg(5'd6, 32'h22);

    // Two-operand and one-operand fetches.
    op_ready = 1'b1;
    send(5'd5, 5'd6, 1'b1);
    wait_idle();
    send(5'd5, 5'd9, 1'b0);
    wait_idle();

    // Write x5 in the accept cycle: bypass must supply 0xAA.
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6; req_use_rs2 = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
    tick();
    req_valid = 1'b0; wb_valid = 1'b0;
    wait_idle();

    // Held operands track writebacks.
    op_ready = 1'b0;
    send(5'd5, 5'd6, 1'b1);
    wait_valid();
    write_reg(5'd6, 32'h99);
    check("snoop_rs2", op_rs2_data, 32'h99);
    check("snoop_rs1_kept", op_rs1_data, 32'hAA);
    write_reg(5'd7, 32'h77);
    check("unrelated_rs1", op_rs1_data, 32'hAA);
    check("unrelated_rs2", op_rs2_data, 32'h99);
    check("held_op_valid", {31'd0, op_valid}, 32'd1);
    op_ready = 1'b1;
    tick();
    wait_idle();

    // x0 write is dropped; x0 reads return zero.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    #1;
    check("x0_write_en", {31'd0, rf_write_en}, 32'd0);
    tick();
    wb_valid = 1'b0;
    send(5'd0, 5'd0, 1'b1);
    wait_idle();

    // Reset while in WAIT2 aborts the request.
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6; req_use_rs2 = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_op_valid", {31'd0, op_valid}, 32'd0);
    check("abort_op_rs1", op_rs1_data, 32'd0);
    check("abort_op_rs2", op_rs2_data, 32'd0);
    tick();
    rst_n = 1'b1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    send(5'd5, 5'd6, 1'b1);
    wait_idle();

    // Random traffic with overlapping writebacks and backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    end
    rand_mode = 1'b0;
    wb_valid = 1'b0;
    op_ready = 1'b1;
    wait_idle();
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/regfile_sequencer.md
# regfile_sequencer

Operand-fetch controller for the core's single-read-port, single-write-port register file. Accepts a decode request naming up to two source registers, issues them to the register file's synchronous read port on consecutive cycles, and presents both operands together to the execute stage through a valid/ready handshake. It also drives the register file's write port from writeback. It guarantees x0 semantics, same-cycle write/read bypass, and that held operands track later writebacks.

## Interface
- No parameters. Data width comes from `cornigera_pkg::DataType`; register addresses are `cornigera_pkg::RegAddrType` (5 bits).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  decode request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_rs1`, `req_rs2`  in  5 each  source register addresses.
- `req_use_rs2`  in  1  0: one-operand instruction; rs2_data returns 0.
- `op_valid`  out  1  operands valid to execute.
- `op_ready`  in  1  execute consumes the operands.
- `op_rs1_data`, `op_rs2_data`  out  DataType each  operand values.
- `wb_valid`  in  1  writeback this cycle. There is no backpressure.
- `wb_rd`  in  5  destination register.
- `wb_data`  in  DataType  writeback value.
- `rf_write_en`, `rf_write_to`, `rf_write_data`  out  1/5/DataType  register-file write port.
- `rf_read_from`  out  5  register-file read address.
- `rf_read_data`  in  DataType  register-file read data, valid one cycle after the address is presented.

## Operation
- States: IDLE, READ2, WAIT2, VALID (`regseq_state_e`).
- IDLE
  - `req_ready`=1; `rf_read_from`=`req_rs1` combinationally.
  - On `req_valid`: latch rs1, rs2 and use_rs2, then go to READ2.
- READ2
  - Capture rs1 into `op_rs1_data`; drive `rf_read_from`=rs2_q.
  - If use_rs2, go to WAIT2. Otherwise set `op_rs2_data`=0 and go to VALID.
- WAIT2: capture rs2 into `op_rs2_data`, then go to VALID.
- VALID
  - `op_valid`=1; operands held stable.
  - On `op_ready`, go to IDLE.
  - `req_ready`=0 in every state except IDLE.
- Write port
  - Combinational pass-through: `rf_write_en`=`wb_valid` && `wb_rd`!=0; `rf_write_to`=`wb_rd`; `rf_write_data`=`wb_data`.
  - Writes to x0 never reach the register file.
- Read/write bypass
  - The register file returns the old value when a write and a read of the same address fall in one cycle.
  - In every cycle a read is issued (IDLE accept, READ2 when use_rs2), the block registers `byp_hit` = (`rf_write_en` && `rf_write_to`==`rf_read_from`) and `byp_data`=`wb_data`.
  - The capture cycle uses `byp_hit ? byp_data : rf_read_data`.
- Snoop
  - After capture, a writeback with `wb_rd`!=0 matching a captured source overwrites that operand register on the same edge.
  - This applies to rs1 in READ2 (after the capture edge), WAIT2 and VALID, and to rs2 in VALID.
  - A write in the capture cycle itself is also covered: the captured value is `wb_data`.
  - Both operands update if rs1==rs2.
- x0: a source of 0 always yields 0. The register file forces this; bypass and snoop exclude rd 0.

## Timing
- Reset values: state IDLE, `op_valid`=0, `req_ready`=1 once `rst_n` is high, operand registers 0, `byp_hit`=0.
- `rf_*` outputs are combinational from state and inputs.
- Reset asserted mid-operation aborts the request without any `op_valid` pulse. Writes in flight on `wb_*` during reset are still passed through combinationally; the register file has no reset.
- Latency, accept edge to `op_valid`: 3 cycles with use_rs2, 2 cycles without.
- Throughput: at best one request per 4 cycles (3 cycles one-operand), given `op_ready` held high.
- `op_valid` and the operands stay stable until `op_ready`, except for snoop updates.
- `req_valid` arriving outside IDLE is ignored until IDLE. The requester must hold it.

## Structure
- `cornigera_pkg` gains:
  - `RegAddrType` (logic [4:0]);
  - `regseq_state_e`;
  - `localparam RegAddrType REG_ZERO = 0`.
- No sub-module. The parent instantiates `registers` beside this block and connects the `rf_*` ports.
- Bypass and snoop compares are small local functions, not separate modules.

## Test plan
- Preload x5=0x11, x6=0x22. Request rs1=5, rs2=6, use_rs2=1 → `op_valid` 3 cycles after accept, rs1=0x11, rs2=0x22.
- Request rs1=5, use_rs2=0 → `op_valid` after 2 cycles, rs2=0.
- Write x5=0xAA in the accept cycle of rs1=5 → captured rs1=0xAA (bypass), not the stale 0x11.
- Hold `op_ready`=0 in VALID. Write x6=0x99 → `op_rs2_data` becomes 0x99 next cycle. A write to x7 leaves the operands unchanged.
- Writeback rd=0, data=0xFFFF → `rf_write_en`=0. A later request rs1=0, rs2=0 → both operands 0.
- Assert `rst_n`=0 while in WAIT2 → IDLE immediately, `op_valid`=0, operands 0. The next request completes normally.
